// File: rtl/iob_sram_loader_pkg.sv
// Shared types and constants for the SRAM byte-stream loader.
// Holds FSM state codes, bytes-per-word and the full write mask.
package iob_sram_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam logic [3:0] WMASK_ALL = 4'hF;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE    = 2'd0;
    localparam state_t S_COLLECT = 2'd1;
    localparam state_t S_WRITE   = 2'd2;
    localparam state_t S_DONE    = 2'd3;

endpackage

// File: rtl/iob_sram_loader_pack.sv
// Byte-to-word packer: little-endian assembly of 4 bytes per word.
// Ports: clk, rst_n, clr (restart count), in_valid/in_data (accepted
// byte), word (assembly register), word_full (4th byte accepted).
module iob_sram_loader_pack
    import iob_sram_loader_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int BYTE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic [DATA_W-1:0] word,
    output logic              word_full
);

    logic [1:0] byte_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            word     <= '0;
        end else if (clr) begin
            byte_cnt <= '0;
        end else if (in_valid) begin
            word[BYTE_W*byte_cnt +: BYTE_W] <= in_data;
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    assign word_full = in_valid &&
                       (byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/iob_sram_loader.sv
// Boot loader: packs a byte stream into words and writes them to
// SRAM port 0 from address 0; otherwise passes the read path through.
// Ports: clk, rst_n, start/load_len (begin load), s_valid/s_data/
// s_ready (byte stream), busy, done (sticky), r_en/r_addr (normal
// read path), sram_csb/web/wmask/addr/din (macro port 0).
module iob_sram_loader
    import iob_sram_loader_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int BYTE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              s_valid,
    input  logic [BYTE_W-1:0] s_data,
    output logic              s_ready,
    output logic              busy,
    output logic              done,
    input  logic              r_en,
    input  logic [ADDR_W-1:0] r_addr,
    output logic              sram_csb,
    output logic              sram_web,
    output logic [3:0]        sram_wmask,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din
);

    state_t              state;
    logic [ADDR_W:0]     len;
    logic [ADDR_W-1:0]   word_addr;
    logic [DATA_W-1:0]   word;
    logic                word_full;
    logic                accept;
    logic                load_go;
    logic                last_word;

    assign s_ready = (state == S_COLLECT);
    assign busy    = (state == S_COLLECT) || (state == S_WRITE);
    assign accept  = s_valid && s_ready;

    // Packer restarts only when a non-empty load is accepted.
    assign load_go = start && (load_len != '0) &&
                     ((state == S_IDLE) || (state == S_DONE));

    assign last_word = ({1'b0, word_addr} == (len - 1'b1));

    iob_sram_loader_pack #(
        .DATA_W (DATA_W),
        .BYTE_W (BYTE_W)
    ) u_pack (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (load_go),
        .in_valid  (accept),
        .in_data   (s_data),
        .word      (word),
        .word_full (word_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            len       <= '0;
            word_addr <= '0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        if (load_len != '0) begin
                            len       <= load_len;
                            word_addr <= '0;
                            done      <= 1'b0;
                            state     <= S_COLLECT;
                        end else begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                S_COLLECT: begin
                    if (word_full) state <= S_WRITE;
                end
                S_WRITE: begin
                    if (last_word) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        word_addr <= word_addr + 1'b1;
                        state     <= S_COLLECT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Port 0 belongs to the loader while busy, else to the read path.
    always_comb begin
        sram_csb   = 1'b1;
        sram_web   = 1'b1;
        sram_wmask = '0;
        sram_addr  = word_addr;
        sram_din   = word;
        if (state == S_WRITE) begin
            sram_csb   = 1'b0;
            sram_web   = 1'b0;
            sram_wmask = WMASK_ALL;
        end else if (!busy) begin
            sram_csb  = ~r_en;
            sram_addr = r_addr;
            sram_din  = '0;
        end
    end

endmodule
